// File: rtl/pmux_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : pmux_arb_if
//  Purpose  : Producer/consumer bundle for the pmux_arb arbitrating mux.
//             Carries the per-channel request/data/grant lines and the
//             valid/ready output stage toward the single consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface pmux_arb_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8,
   parameter int IDX_W    = $clog2(CHANNELS)
);

   // Producer side: flattened data, channel k at [k*WIDTH +: WIDTH]
   logic [CHANNELS-1:0]       req_i;
   logic [CHANNELS*WIDTH-1:0] data_i;
   logic [CHANNELS-1:0]       grant_o;

   // Consumer side: one-entry registered output stage
   logic                      valid_o;
   logic                      ready_i;
   logic [WIDTH-1:0]          q_o;
   logic [IDX_W-1:0]          idx_o;

   // The arbiter itself takes the slave view
   modport slave (
      input  req_i,
      input  data_i,
      input  ready_i,
      output grant_o,
      output valid_o,
      output q_o,
      output idx_o
   );

   // Whatever drives requests and consumes words takes the master view
   modport master (
      output req_i,
      output data_i,
      output ready_i,
      input  grant_o,
      input  valid_o,
      input  q_o,
      input  idx_o
   );

endinterface
`default_nettype wire

// File: rtl/pmux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : pmux_arb
//  Purpose  : Selects one of CHANNELS request/data sources per cycle using
//             fixed-priority (MODE 0) or round-robin (MODE 1) arbitration and
//             registers the winning word into a one-entry valid/ready stage.
//             grant_o is a combinational one-hot pop strobe to the winner.
//  Revision : 1.0  initial release
// ============================================================================
module pmux_arb #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 8,
   parameter int IDX_W    = $clog2(CHANNELS),
   parameter int MODE     = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   pmux_arb_if.slave   bus
);

   // Channel count and last index at index-compatible widths
   localparam logic [IDX_W:0]   C_CH   = (IDX_W+1)'(CHANNELS);
   localparam logic [IDX_W-1:0] C_LAST = IDX_W'(CHANNELS-1);

   // Output stage and round-robin pointer
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  q_q,     q_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

   // Arbitration results
   logic              load;
   logic [IDX_W-1:0]  win;
   logic [WIDTH-1:0]  win_data;
   logic [CHANNELS-1:0] grant;

   // A word is taken when someone requests and the stage is empty or draining;
   // reset suppresses any grant so no producer pops a word that gets discarded.
   always_comb begin
      load = !rst_i && (|bus.req_i) && (!valid_q || bus.ready_i);
   end

   generate
      if (MODE == 0) begin : g_fixed
         // Fixed priority: scan downward so the lowest set index is left last
         always_comb begin
            win = '0;
            for (int i = CHANNELS-1; i >= 0; i--) begin
               if (bus.req_i[i]) begin
                  win = IDX_W'(i);
               end
            end
         end
      end else begin : g_rr
         logic [IDX_W:0] pos;
         logic           found;

         // Round robin: walk upward from rr_ptr modulo CHANNELS, first hit wins
         always_comb begin
            win   = '0;
            found = 1'b0;
            pos   = '0;
            for (int i = 0; i < CHANNELS; i++) begin
               pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
               if (pos >= C_CH) begin
                  pos = pos - C_CH;
               end
               if (!found && bus.req_i[pos[IDX_W-1:0]]) begin
                  win   = pos[IDX_W-1:0];
                  found = 1'b1;
               end
            end
         end
      end
   endgenerate

   // Decode the winner into the data select and the one-hot pop strobe
   always_comb begin
      win_data = '0;
      grant    = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (win == IDX_W'(k)) begin
            win_data = bus.data_i[k*WIDTH +: WIDTH];
            grant[k] = load;
         end
      end
   end

   // Next state of the output stage; the pointer only moves on a grant
   always_comb begin
      valid_d  = valid_q;
      q_d      = q_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      if (load) begin
         valid_d = 1'b1;
         q_d     = win_data;
         idx_d   = win;
         if (MODE == 1) begin
            rr_ptr_d = (win == C_LAST) ? '0 : win + IDX_W'(1);
         end
      end else if (valid_q && bus.ready_i) begin
         // Drain with nothing to replace it: data and index keep stale values
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         q_q      <= '0;
         idx_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         q_q      <= q_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.grant_o = grant;
   assign bus.valid_o = valid_q;
   assign bus.q_o     = q_q;
   assign bus.idx_o   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_pmux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmux_arb
//  Purpose  : Directed vector bench for pmux_arb; one fixed-priority and one
//             round-robin instance share clock and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmux_arb;

   localparam int WIDTH    = 16;
   localparam int CHANNELS = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pmux_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) if0 ();
   pmux_arb_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) if1 ();

   pmux_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(0)) u_fixed (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if0)
   );

   pmux_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(1)) u_rr (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if1)
   );

   // One cycle: inputs, grant expected before the edge, outputs after it
   typedef struct {
      logic        rst;
      logic        dut;     // 0 = fixed priority, 1 = round robin
      logic [7:0]  req;
      logic        ready;
      logic [7:0]  g;
      logic        v;
      logic [15:0] q;
      logic [2:0]  idx;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic d, input logic [7:0] req,
                               input logic rdy, input logic [7:0] g, input logic v,
                               input logic [15:0] q, input logic [2:0] idx);
      vec_t e;
      e.rst = r; e.dut = d; e.req = req; e.ready = rdy;
      e.g = g; e.v = v; e.q = q; e.idx = idx;
      tbl.push_back(e);
   endfunction

   initial begin
      logic [CHANNELS*WIDTH-1:0] base_data;
      logic                      seen;

      for (int k = 0; k < CHANNELS; k++) begin
         base_data[k*WIDTH +: WIDTH] = 16'h0100 + 16'(k);
      end
      rst = 1'b1;
      if0.req_i = '0; if0.ready_i = 1'b1; if0.data_i = base_data;
      if1.req_i = '0; if1.ready_i = 1'b1; if1.data_i = base_data;

      // Reset with all requests high: no grants, everything cleared
      add(1, 0, 8'hFF, 1, 8'h00, 0, 16'h0000, 3'd0);
      add(1, 0, 8'hFF, 1, 8'h00, 0, 16'h0000, 3'd0);
      add(1, 1, 8'hFF, 1, 8'h00, 0, 16'h0000, 3'd0);
      // Fixed priority, lowest set bit is channel 2
      add(0, 0, 8'hA4, 1, 8'h04, 1, 16'h0102, 3'd2);
      add(0, 0, 8'hA4, 1, 8'h04, 1, 16'h0102, 3'd2);
      add(0, 0, 8'hA4, 1, 8'h04, 1, 16'h0102, 3'd2);
      // Drain, then idle with ready low: stale data/index remain
      add(0, 0, 8'h00, 1, 8'h00, 0, 16'h0102, 3'd2);
      add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0102, 3'd2);
      // Load into an empty stage while ready is low, then 3 stalled cycles
      add(0, 0, 8'h08, 0, 8'h08, 1, 16'h0103, 3'd3);
      add(0, 0, 8'h01, 0, 8'h00, 1, 16'h0103, 3'd3);
      add(0, 0, 8'hFF, 0, 8'h00, 1, 16'h0103, 3'd3);
      add(0, 0, 8'h01, 0, 8'h00, 1, 16'h0103, 3'd3);
      // Ready rises: grant in the same cycle, new word one edge later
      add(0, 0, 8'h01, 1, 8'h01, 1, 16'h0100, 3'd0);
      add(0, 0, 8'h80, 1, 8'h80, 1, 16'h0107, 3'd7);
      add(0, 0, 8'hC0, 1, 8'h40, 1, 16'h0106, 3'd6);
      add(0, 0, 8'h00, 1, 8'h00, 0, 16'h0106, 3'd6);
      // Round robin over all channels, back-to-back, wrapping once
      for (int i = 0; i < 10; i++) begin
         add(0, 1, 8'hFF, 1, 8'(1 << (i % 8)), 1, 16'h0100 + 16'(i % 8), 3'(i % 8));
      end
      // Sparse wrap: pointer at 2 so channel 7 first, then 0, 7, 0
      add(0, 1, 8'h81, 1, 8'h80, 1, 16'h0107, 3'd7);
      add(0, 1, 8'h81, 1, 8'h01, 1, 16'h0100, 3'd0);
      add(0, 1, 8'h81, 1, 8'h80, 1, 16'h0107, 3'd7);
      add(0, 1, 8'h81, 1, 8'h01, 1, 16'h0100, 3'd0);
      // Reset, grants 0,1,2, reset with a word held, first grant is channel 0
      add(1, 1, 8'hFF, 1, 8'h00, 0, 16'h0000, 3'd0);
      add(0, 1, 8'hFF, 1, 8'h01, 1, 16'h0100, 3'd0);
      add(0, 1, 8'hFF, 1, 8'h02, 1, 16'h0101, 3'd1);
      add(0, 1, 8'hFF, 1, 8'h04, 1, 16'h0102, 3'd2);
      add(1, 1, 8'hFF, 1, 8'h00, 0, 16'h0000, 3'd0);
      add(0, 1, 8'hFF, 1, 8'h01, 1, 16'h0100, 3'd0);
      // Stall must not move the pointer: next grant is channel 1
      add(0, 1, 8'hFF, 0, 8'h00, 1, 16'h0100, 3'd0);
      add(0, 1, 8'hFF, 1, 8'h02, 1, 16'h0101, 3'd1);
      add(0, 1, 8'h00, 0, 8'h00, 1, 16'h0101, 3'd1);
      add(0, 1, 8'h00, 1, 8'h00, 0, 16'h0101, 3'd1);

      for (int r = 0; r < tbl.size(); r++) begin
         @(negedge clk);
         rst = tbl[r].rst;
         if (tbl[r].dut == 1'b0) begin
            if0.req_i = tbl[r].req; if0.ready_i = tbl[r].ready;
            if1.req_i = '0;         if1.ready_i = 1'b1;
         end else begin
            if1.req_i = tbl[r].req; if1.ready_i = tbl[r].ready;
            if0.req_i = '0;         if0.ready_i = 1'b1;
         end
         #1;
         chk("grant", r, 32'(tbl[r].dut ? if1.grant_o : if0.grant_o), 32'(tbl[r].g));
         @(posedge clk);
         #1;
         chk("valid", r, 32'(tbl[r].dut ? if1.valid_o : if0.valid_o), 32'(tbl[r].v));
         chk("q",     r, 32'(tbl[r].dut ? if1.q_o     : if0.q_o),     32'(tbl[r].q));
         chk("idx",   r, 32'(tbl[r].dut ? if1.idx_o   : if0.idx_o),   32'(tbl[r].idx));
      end

      // Stalled word must ignore a change on its source data
      @(negedge clk);
      rst = 1'b0;
      if0.req_i = 8'h08; if0.ready_i = 1'b1;
      #1;
      chk("seqA_grant", 0, 32'(if0.grant_o), 32'h08);
      @(posedge clk); #1;
      chk("seqA_q", 0, 32'(if0.q_o), 32'h0103);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         if0.req_i = '0; if0.ready_i = 1'b0;
         if0.data_i[3*WIDTH +: WIDTH] = 16'hBEEF;
         #1;
         chk("seqA_stall_grant", c, 32'(if0.grant_o), 32'h00);
         @(posedge clk); #1;
         chk("seqA_stall_valid", c, 32'(if0.valid_o), 32'h1);
         chk("seqA_stall_q", c, 32'(if0.q_o), 32'h0103);
      end
      @(negedge clk);
      if0.data_i = base_data; if0.ready_i = 1'b1;
      @(posedge clk); #1;
      chk("seqA_drain_valid", 0, 32'(if0.valid_o), 32'h0);
      chk("seqA_drain_q", 0, 32'(if0.q_o), 32'h0103);

      // Bounded wait for a round-robin word from channel 4 (pointer at 2)
      @(negedge clk);
      if1.req_i = 8'h10; if1.ready_i = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(posedge clk); #1;
         seen = if1.valid_o;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL seqB_timeout: got valid 0 expected 1 within 4 cycles");
      end else begin
         chk("seqB_idx", 0, 32'(if1.idx_o), 32'h4);
         chk("seqB_q", 0, 32'(if1.q_o), 32'h0104);
      end
      @(negedge clk);
      if1.req_i = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
